// File: rtl/mash_pkg.sv
// Shared constants and helpers for the MASH noise-cancellation network.
package mash_pkg;

    localparam int unsigned MASH_MAX_ORDER_LIMIT = 6;
    localparam int unsigned ORDER_W              = 3;
    localparam int unsigned CNT_W                = 3;

    // Map a requested order onto 1..max_ord.
    function automatic logic [ORDER_W-1:0] clamp_order(input logic [ORDER_W-1:0] ord,
                                                       input int unsigned        max_ord);
        logic [ORDER_W-1:0] r;
        r = ord;
        if (ord == '0) begin
            r = ORDER_W'(1);
        end else if (32'(ord) > max_ord) begin
            r = ORDER_W'(max_ord);
        end
        return r;
    endfunction

    // Lowest legal output value for order n.
    function automatic int out_range_lo(input int n);
        return -((1 << (n - 1)) - 1);
    endfunction

    // Highest legal output value for order n.
    function automatic int out_range_hi(input int n);
        return 1 << (n - 1);
    endfunction

endpackage

// File: rtl/mash_diff_stage.sv
// One differencer of the cascade: g_c_o = carry + g(n-1) - g(n).
module mash_diff_stage #(
    parameter int unsigned W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                carry_i,
    input  logic signed [W-1:0] g_i,
    output logic signed [W-1:0] g_c_o
);

    logic signed [W-1:0] hist_q;
    logic signed [W-1:0] hist_d;

    // History captures the downstream value on each enabled edge; clear wins.
    always_comb begin
        hist_d = hist_q;
        if (clr) begin
            hist_d = '0;
        end else if (en) begin
            hist_d = g_i;
        end
    end

    // History register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign g_c_o = $signed({{(W-1){1'b0}}, carry_i}) + hist_q - g_i;

endmodule

// File: rtl/mash_ncl_param.sv
// Run-time order-selectable MASH 1-1-...-1 noise-cancellation network.
module mash_ncl_param
    import mash_pkg::*;
#(
    parameter int unsigned MAX_ORDER = 4,
    parameter int unsigned OUT_W     = MAX_ORDER + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [ORDER_W-1:0]      order_i,
    input  logic [MAX_ORDER-1:0]    carry_i,
    output logic signed [OUT_W-1:0] out_s,
    output logic [MAX_ORDER-1:0]    out_u,
    output logic                    out_valid,
    output logic                    settled,
    output logic                    range_err
);

    logic [ORDER_W-1:0]      order_q, order_d, order_req_c, n_m1_c;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] out_s_q, out_s_d;
    logic [MAX_ORDER-1:0]    out_u_q, out_u_d;
    logic                    valid_q, valid_d;
    logic                    settled_q, settled_d;
    logic                    err_q, err_d;
    logic                    order_chg_c, adv_c;
    logic [MAX_ORDER-1:0]    carry_m_c;
    logic signed [OUT_W-1:0] g_c [MAX_ORDER];
    logic signed [OUT_W-1:0] y_c, lo_c, hi_c;

    assign order_req_c = clamp_order(order_i, MAX_ORDER);
    assign order_chg_c = (order_req_c != order_q);
    assign adv_c       = en && !order_chg_c;
    assign n_m1_c      = order_q - ORDER_W'(1);
    assign lo_c        = OUT_W'(out_range_lo(int'(order_q)));
    assign hi_c        = OUT_W'(out_range_hi(int'(order_q)));

    // Stages above the active order see zero carries.
    always_comb begin
        carry_m_c = '0;
        for (int k = 0; k < int'(MAX_ORDER); k++) begin
            carry_m_c[k] = carry_i[k] && (ORDER_W'(k) < order_q);
        end
    end

    assign g_c[MAX_ORDER-1] = $signed({{(OUT_W-1){1'b0}}, carry_m_c[MAX_ORDER-1]});

    for (genvar k = 0; k < int'(MAX_ORDER) - 1; k++) begin : g_stage
        mash_diff_stage #(.W(OUT_W)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (adv_c),
            .clr    (order_chg_c),
            .carry_i(carry_m_c[k]),
            .g_i    (g_c[k+1]),
            .g_c_o  (g_c[k])
        );
    end

    assign y_c = g_c[0];

    // Next-state: order change flushes everything but the sticky error; en advances.
    always_comb begin
        order_d   = order_q;
        cnt_d     = cnt_q;
        out_s_d   = out_s_q;
        out_u_d   = out_u_q;
        valid_d   = 1'b0;
        settled_d = settled_q;
        err_d     = err_q;
        if (order_chg_c) begin
            order_d   = order_req_c;
            cnt_d     = '0;
            out_s_d   = '0;
            out_u_d   = '0;
            settled_d = 1'b0;
        end else if (en) begin
            out_s_d = y_c;
            out_u_d = MAX_ORDER'(y_c + (hi_c - OUT_W'(1)));
            valid_d = 1'b1;
            if (cnt_q < n_m1_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if ((cnt_q + CNT_W'(1)) >= n_m1_c) begin
                settled_d = 1'b1;
            end
            if ((y_c < lo_c) || (y_c > hi_c)) begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            order_q   <= order_req_c;
            cnt_q     <= '0;
            out_s_q   <= '0;
            out_u_q   <= '0;
            valid_q   <= 1'b0;
            settled_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            order_q   <= order_d;
            cnt_q     <= cnt_d;
            out_s_q   <= out_s_d;
            out_u_q   <= out_u_d;
            valid_q   <= valid_d;
            settled_q <= settled_d;
            err_q     <= err_d;
        end
    end

    assign out_s     = out_s_q;
    assign out_u     = out_u_q;
    assign out_valid = valid_q;
    assign settled   = settled_q;
    assign range_err = err_q;

endmodule

// File: tb/tb_mash_ncl_param.sv
// Scoreboard bench for mash_ncl_param against a binomial-expansion reference model.
module tb_mash_ncl_param;

    localparam int MO    = 4;
    localparam int OW    = MO + 1;
    localparam int NOPIN = 9999;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [2:0]           order_i;
    logic [MO-1:0]        carry_i;
    logic signed [OW-1:0] out_s;
    logic [MO-1:0]        out_u;
    logic                 out_valid;
    logic                 settled;
    logic                 range_err;

    mash_ncl_param #(.MAX_ORDER(MO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .order_i  (order_i),
        .carry_i  (carry_i),
        .out_s    (out_s),
        .out_u    (out_u),
        .out_valid(out_valid),
        .settled  (settled),
        .range_err(range_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int s;
        int u;
        bit v;
        bit st;
        bit err;
        int pin;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: carries of enabled samples since last clear, newest first.
    bit [MO-1:0] m_hist[$];
    int m_order, m_s, m_u, m_cnt;
    bit m_v, m_st, m_err;

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic int clampm(input int o);
        if (o == 0) return 1;
        if (o > MO) return MO;
        return o;
    endfunction

    // y = sum_k (z^-1 - 1)^(k-1) c_k, expanded binomially over past samples.
    function automatic int ref_y();
        int y = 0;
        for (int k = 1; k <= m_order; k++) begin
            for (int j = 0; j <= k - 1; j++) begin
                if (j < m_hist.size() && m_hist[j][k-1]) begin
                    y += binom(k - 1, j) * ((((k - 1 - j) % 2) != 0) ? -1 : 1);
                end
            end
        end
        return y;
    endfunction

    task automatic step(input bit r, input bit e, input int o, input bit [MO-1:0] c, input int pin);
        exp_t x;
        int   oc;
        int   y;
        int   need;
        @(negedge clk);
        rst_n   = r;
        en      = e;
        order_i = 3'(o);
        carry_i = c;
        oc = clampm(o);
        if (!r) begin
            m_hist.delete();
            m_order = oc; m_s = 0; m_u = 0; m_v = 0; m_st = 0; m_err = 0; m_cnt = 0;
        end else if (oc != m_order) begin
            m_hist.delete();
            m_order = oc; m_s = 0; m_u = 0; m_v = 0; m_st = 0; m_cnt = 0;
        end else if (e) begin
            m_hist.push_front(c);
            if (m_hist.size() > 8) void'(m_hist.pop_back());
            y = ref_y();
            m_s = y;
            m_u = (y + (1 << (m_order - 1)) - 1) & ((1 << MO) - 1);
            m_v = 1;
            m_cnt++;
            need = (m_order > 1) ? m_order - 1 : 1;
            if (m_cnt >= need) m_st = 1;
            if (y < -((1 << (m_order - 1)) - 1) || y > (1 << (m_order - 1))) m_err = 1;
        end else begin
            m_v = 0;
        end
        x.s = m_s; x.u = m_u; x.v = m_v; x.st = m_st; x.err = m_err; x.pin = pin;
        exp_q.push_back(x);
    endtask

    // Monitor: pop one expectation per edge and compare the registered outputs.
    initial begin
        exp_t     x;
        bit [11:0] act, req;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                act = {out_valid, out_s, out_u, settled, range_err};
                req = {x.v, 5'(x.s), 4'(x.u), x.st, x.err};
                checks++;
                if (act !== req) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got v=%b s=%0d u=%0d st=%b err=%b, want v=%b s=%0d u=%0d st=%b err=%b",
                             $time, out_valid, out_s, out_u, settled, range_err,
                             x.v, x.s, x.u, x.st, x.err);
                end
                if (x.pin != NOPIN) begin
                    checks++;
                    if (int'(out_s) != x.pin) begin
                        errors++;
                        $display("FAIL directed_out_s t=%0t: got %0d want %0d", $time, out_s, x.pin);
                    end
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        order_i = 3'd3;
        carry_i = '0;

        step(0, 0, 3, 4'b0000, 0);
        step(0, 1, 3, 4'b1111, 0);

        // All-zero carries at order 3.
        for (int i = 0; i < 8; i++) step(1, 1, 3, 4'b0000, 0);

        // c3 then c2 impulse responses.
        step(1, 1, 3, 4'b0100, 1);
        step(1, 1, 3, 4'b0000, -2);
        step(1, 1, 3, 4'b0000, 1);
        step(1, 1, 3, 4'b0000, 0);
        step(1, 1, 3, 4'b0010, -1);
        step(1, 1, 3, 4'b0000, 1);
        step(1, 1, 3, 4'b0000, 0);

        // Order 4: full-scale DC, then c4 impulse.
        step(1, 1, 4, 4'b1111, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 4, 4'b1111, NOPIN);
        step(1, 1, 4, 4'b1111, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 4, 4'b0000, NOPIN);
        step(1, 1, 4, 4'b1000, -1);
        step(1, 1, 4, 4'b0000, 3);
        step(1, 1, 4, 4'b0000, -3);
        step(1, 1, 4, 4'b0000, 1);
        step(1, 1, 4, 4'b0000, 0);

        // Order changes mid-stream; en=1 carries on the change edge are discarded.
        step(1, 1, 3, 4'b0111, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 3, 4'($urandom), NOPIN);
        step(1, 1, 2, 4'b0011, 0);
        step(1, 1, 2, 4'($urandom), NOPIN);
        step(1, 1, 2, 4'($urandom), NOPIN);
        step(1, 1, 7, 4'b1111, 0);
        step(1, 1, 7, 4'b1000, -1);
        step(1, 1, 4, 4'b0000, 3);
        step(1, 1, 4, 4'b0000, -3);
        step(1, 1, 4, 4'b0000, 1);
        step(1, 1, 0, 4'b0001, 0);
        step(1, 1, 0, 4'b0001, 1);

        // en gaps in the middle of a c4 impulse, then reset inside the response.
        step(1, 1, 4, 4'b0000, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 4, 4'b0000, 0);
        step(1, 1, 4, 4'b1000, -1);
        for (int i = 0; i < 5; i++) step(1, 0, 4, 4'($urandom), -1);
        step(1, 1, 4, 4'b0000, 3);
        step(0, 1, 4, 4'b1111, 0);
        step(1, 1, 4, 4'b0000, 0);

        // Random carries with random en gaps at every order.
        for (int o = 1; o <= MO; o++) begin
            step(1, 0, o, 4'b0000, 0);
            for (int i = 0; i < 2000; i++) begin
                step(1, ($urandom_range(0, 4) != 0), o, 4'($urandom), NOPIN);
            end
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
